pm_loader: RTL and testbench
============================

# pm_loader

Program-memory loader and CPU run controller for the 4-bit microprocessor. It holds the core in reset and streams bytes from an external byte source into the 256x8 program memory over a valid/ready handshake. When the load completes it releases the core to execute from address 0. It sits between the external load port and the processor's reset input and program-memory write port.

## Interface

- RESET_HOLD, 4: cycles cpu_reset stays high after reset or after a load, before entering RUN (min 2, covers the core's reset synchroniser)
- TIMEOUT, 255: idle cycles in LOAD with no accepted byte before abort to ERR
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- load_req  in  1  level/pulse; starts a load when sampled high in HOLD, RUN or ERR
- load_len  in  8  byte count, sampled on load start; 0 means 256
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  program byte
- byte_ready  out  1  loader accepts byte this cycle
- pm_wren  out  1  program-memory write enable
- pm_wr_addr  out  8  program-memory write address
- pm_wr_data  out  8  program-memory write data
- cpu_reset  out  1  drives the processor's reset input
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse on the final byte's write
- error  out  1  high in ERR
- checksum  out  8  mod-256 sum of bytes accepted in the current/last load

## Operation

- States: HOLD, RUN, LOAD, ERR.
- Reset: state=HOLD, hold counter=0, address=0, checksum=0.
  - All outputs 0 except cpu_reset=1.
- HOLD:
  - cpu_reset=1; counter increments.
  - At count RESET_HOLD-1, go to RUN next cycle.
  - load_req=1 overrides and goes to LOAD.
- RUN: cpu_reset=0; load_req=1 goes to LOAD.
- Load start, from HOLD, RUN or ERR:
  - Capture load_len (0 becomes 256).
  - Clear address, checksum and idle counter.
  - Enter LOAD.
- LOAD:
  - cpu_reset=1, busy=1.
  - byte_ready=1 except in the cycle following acceptance of the final byte.
  - Transfer occurs when byte_valid and byte_ready are both high.
  - On each transfer: checksum += byte_data (8-bit wrap); address increments (8-bit); idle counter clears.
  - Otherwise the idle counter increments.
  - load_req is ignored in LOAD.
- Final byte (transfer count reaches len): go to HOLD (counter=0), then RUN after RESET_HOLD cycles.
- Timeout: idle counter reaches TIMEOUT, go to ERR.
  - The partial image is left in memory.
  - checksum holds the partial sum.
- ERR:
  - cpu_reset=1, error=1, byte_ready=0.
  - Leaves only on load_req (or reset).
- Simultaneous events:
  - Transfer and timeout in the same cycle: the transfer wins and the counter clears.
  - reset outranks everything.
- Reset mid-load: writes stop immediately (pm_wren=0 the next cycle), state returns to HOLD, checksum=0.
- len=256: addresses 0..255 are written; the address wraps to 0 with no extra write.

## Timing

- LOAD is entered the cycle after load_req is sampled; byte_ready is high in that first LOAD cycle.
- Write latency is 1 cycle. A byte accepted at edge N gives pm_wren=1 with registered pm_wr_addr and pm_wr_data during cycle N+1.
  - Back-to-back transfers therefore produce back-to-back writes.
  - Program memory clocks on the inverted clock, so the write lands mid-cycle.
- done pulses in the same cycle as the final pm_wren; state=HOLD in that cycle.
- cpu_reset is high from the load_req sample edge until the RESET_HOLD count after the final write.
- The first RUN cycle has cpu_reset=0; the core fetches address 0 afterwards.
- checksum is registered and valid the cycle after each transfer.

## Test plan

- Power-up:
  - Stimulus: reset high for 3 cycles, then low; RESET_HOLD=4.
  - Required: cpu_reset=1 for exactly 4 cycles after reset deasserts, then 0.
  - Required: busy, error and pm_wren all 0 throughout.
- Full-rate load:
  - Stimulus: load_len=4; bytes 0x12, 0x34, 0x56, 0x78 with byte_valid continuously high.
  - Required: writes to addresses 0..3 on 4 consecutive cycles.
  - Required: done coincident with the address-3 write; checksum=0x14.
  - Required: cpu_reset falls RESET_HOLD cycles after the last write.
- Throttled source:
  - Stimulus: load_len=3; byte_valid toggles every other cycle.
  - Required: exactly 3 writes, to addresses 0, 1, 2, each 1 cycle after its transfer.
  - Required: no write in gap cycles.
- Timeout:
  - Stimulus: TIMEOUT=8; load_len=5; send 2 bytes, then hold byte_valid low.
  - Required: ERR entered after 8 idle cycles; error=1, cpu_reset=1, byte_ready=0.
  - Required: a new load_req restarts at address 0 with checksum 0.
- Wrap:
  - Stimulus: load_len=0 (256 bytes), byte value = index.
  - Required: 256 writes to addresses 0..255; checksum=0x80.
  - Required: no write after 255; the address returns to 0.
- Reset mid-load:
  - Stimulus: assert reset after the 2nd transfer of a 6-byte load.
  - Required: pm_wren=0 from the next cycle; HOLD with checksum=0.
  - Required: load_req is ignored while reset is high.

Source files
------------

// File: rtl/pm_loader.sv
// Program-memory loader / core run controller: holds the core in reset while streaming bytes into program memory.
// Writes land 1 cycle after each accepted byte; byte_ready is high only in LOAD, so the source stalls in every other state.
module pm_loader #(
  parameter int RESET_HOLD = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_req,
  input  logic [7:0] load_len,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       pm_wren,
  output logic [7:0] pm_wr_addr,
  output logic [7:0] pm_wr_data,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [8:0]    len_q, len_d;
  logic [8:0]    xfer_cnt_q, xfer_cnt_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    checksum_q, checksum_d;
  logic          pm_wren_q, pm_wren_d;
  logic [7:0]    pm_wr_addr_q, pm_wr_addr_d;
  logic [7:0]    pm_wr_data_q, pm_wr_data_d;
  logic          done_q, done_d;

  logic load_start, xfer, last_xfer, hold_expired, timed_out;

  assign load_start   = load_req && (state_q != S_LOAD);
  assign xfer         = byte_valid && byte_ready;
  assign last_xfer    = xfer && ((xfer_cnt_q + 9'd1) == len_q);
  assign hold_expired = (hold_cnt_q == HOLD_LAST);
  // A transfer in the would-be timeout cycle keeps the load alive.
  assign timed_out    = !xfer && (idle_cnt_q == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      len_q        <= '0;
      xfer_cnt_q   <= '0;
      addr_q       <= '0;
      checksum_q   <= '0;
      pm_wren_q    <= 1'b0;
      pm_wr_addr_q <= '0;
      pm_wr_data_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      len_q        <= len_d;
      xfer_cnt_q   <= xfer_cnt_d;
      addr_q       <= addr_d;
      checksum_q   <= checksum_d;
      pm_wren_q    <= pm_wren_d;
      pm_wr_addr_q <= pm_wr_addr_d;
      pm_wr_data_q <= pm_wr_data_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (load_start)        state_d = S_LOAD;
        else if (hold_expired) state_d = S_RUN;
      end
      S_RUN:  if (load_start) state_d = S_LOAD;
      S_LOAD: begin
        if (last_xfer)      state_d = S_HOLD;
        else if (timed_out) state_d = S_ERR;
      end
      S_ERR:  if (load_start) state_d = S_LOAD;
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    hold_cnt_d   = (state_q == S_HOLD) ? hold_cnt_q + 1'b1 : '0;
    idle_cnt_d   = idle_cnt_q;
    len_d        = len_q;
    xfer_cnt_d   = xfer_cnt_q;
    addr_d       = addr_q;
    checksum_d   = checksum_q;
    pm_wren_d    = xfer;
    pm_wr_addr_d = xfer ? addr_q : pm_wr_addr_q;
    pm_wr_data_d = xfer ? byte_data : pm_wr_data_q;
    done_d       = last_xfer;
    if (load_start) begin
      len_d      = (load_len == 8'd0) ? 9'd256 : {1'b0, load_len};
      idle_cnt_d = '0;
      xfer_cnt_d = '0;
      addr_d     = '0;
      checksum_d = '0;
    end else if (xfer) begin
      idle_cnt_d = '0;
      xfer_cnt_d = xfer_cnt_q + 9'd1;
      addr_d     = addr_q + 8'd1;
      checksum_d = checksum_q + byte_data;
    end else if (state_q == S_LOAD) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_comb begin
    byte_ready = (state_q == S_LOAD);
    busy       = (state_q == S_LOAD);
    error      = (state_q == S_ERR);
    cpu_reset  = (state_q != S_RUN);
    pm_wren    = pm_wren_q;
    pm_wr_addr = pm_wr_addr_q;
    pm_wr_data = pm_wr_data_q;
    done       = done_q;
    checksum   = checksum_q;
  end

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: directed plan scenarios plus random traffic, all checked every cycle against a transaction-level model.
module tb_pm_loader;
  localparam int RH = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0;
  logic [7:0] load_len = 8'd0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic       byte_ready, pm_wren, cpu_reset, busy, done, error;
  logic [7:0] pm_wr_addr, pm_wr_data, checksum;

  pm_loader #(.RESET_HOLD(RH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .pm_wren(pm_wren), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] wr_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h want 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the loader is doing, not how. Initial values are the reset state.
  bit         m_load = 0, m_err = 0, m_wr = 0, m_done = 0;
  int         m_hold = RH, m_left = 0, m_idle = 0;
  logic [7:0] m_addr = 8'd0, m_sum = 8'd0, m_wa = 8'd0, m_wd = 8'd0;

  // Inputs only change just after posedge, so at negedge they equal what the next posedge samples.
  task automatic model_step();
    bit acc;
    if (reset) begin
      m_load = 0; m_err = 0; m_hold = RH; m_sum = 8'd0; m_addr = 8'd0;
      m_wr = 0; m_done = 0; m_idle = 0; m_left = 0;
      return;
    end
    acc    = m_load && byte_valid;
    m_wr   = acc;
    m_done = acc && (m_left == 1);
    if (acc) begin
      m_wa = m_addr;
      m_wd = byte_data;
    end
    if (!m_load && load_req) begin
      m_load = 1; m_err = 0; m_hold = 0; m_idle = 0;
      m_left = (load_len == 8'd0) ? 256 : int'(load_len);
      m_addr = 8'd0; m_sum = 8'd0;
    end else if (m_load) begin
      if (acc) begin
        m_sum  = m_sum + byte_data;
        m_addr = m_addr + 8'd1;
        m_left--;
        m_idle = 0;
        if (m_left == 0) begin
          m_load = 0;
          m_hold = RH;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_load = 0;
          m_err  = 1;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk1("cpu_reset", cpu_reset, m_load || m_err || (m_hold > 0));
    chk1("busy", busy, m_load);
    chk1("error", error, m_err);
    chk1("byte_ready", byte_ready, m_load);
    chk1("pm_wren", pm_wren, m_wr);
    chk1("done", done, m_done);
    chk8("checksum", checksum, m_sum);
    if (m_wr) begin
      chk8("pm_wr_addr", pm_wr_addr, m_wa);
      chk8("pm_wr_data", pm_wr_data, m_wd);
    end
    if (pm_wren === 1'b1) wr_q.push_back({pm_wr_addr, pm_wr_data});
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [7:0] len);
    load_req = 1'b1;
    load_len = len;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int w = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    while (byte_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_budget: byte_ready stayed low, want high");
    end
    tick();
    byte_valid = 1'b0;
  endtask

  // Counts cycles, starting with the current one, for which cpu_reset stays high.
  task automatic hold_cycles(output int n);
    n = 0;
    while (cpu_reset === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int bad;
    tick(); tick(); tick();
    reset = 1'b0;

    // Power-up
    hold_cycles(n);
    chkn("powerup_hold_cycles", n, 4);

    // Full-rate load
    wr_q.delete();
    load_start(8'd4);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk1("full_done", done, 1'b1);
    chk8("full_last_addr", pm_wr_addr, 8'd3);
    chk8("full_checksum", checksum, 8'h14);
    hold_cycles(n);
    chkn("full_release_cycles", n, 4);
    chkn("full_writes", wr_q.size(), 4);
    if (wr_q.size() == 4) begin
      chk8("full_w3_addr", wr_q[3][15:8], 8'd3);
      chk8("full_w0_data", wr_q[0][7:0], 8'h12);
    end

    // Throttled source
    wr_q.delete();
    load_start(8'd3);
    send(8'hA1); tick(); send(8'hB2); tick(); send(8'hC3);
    hold_cycles(n);
    chkn("thr_writes", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      chk8("thr_w1_addr", wr_q[1][15:8], 8'd1);
      chk8("thr_w2", wr_q[2][7:0], 8'hC3);
    end

    // Timeout, then restart from ERR
    load_start(8'd5);
    send(8'hA0); send(8'h0B);
    n = 0;
    while (error !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chkn("timeout_idle_cycles", n, 8);
    chk1("err_cpu_reset", cpu_reset, 1'b1);
    chk1("err_byte_ready", byte_ready, 1'b0);
    chk8("err_partial_sum", checksum, 8'hAB);
    tick(); tick(); tick();
    chk1("err_sticky", error, 1'b1);
    wr_q.delete();
    load_start(8'd2);
    chk8("restart_checksum", checksum, 8'h00);
    chk1("restart_busy", busy, 1'b1);
    send(8'h5A); send(8'hC3);
    hold_cycles(n);
    chkn("restart_writes", wr_q.size(), 2);
    if (wr_q.size() == 2) chk8("restart_w0_addr", wr_q[0][15:8], 8'd0);

    // 256-byte wrap
    wr_q.delete();
    load_start(8'd0);
    for (int i = 0; i < 256; i++) send(8'(i));
    chk8("wrap_checksum", checksum, 8'h80);
    hold_cycles(n);
    chkn("wrap_writes", wr_q.size(), 256);
    bad = 0;
    foreach (wr_q[i]) if (wr_q[i] != {8'(i), 8'(i)}) bad++;
    chkn("wrap_content", bad, 0);

    // Reset mid-load
    load_start(8'd6);
    send(8'h11); send(8'h22);
    reset = 1'b1; load_req = 1'b1; byte_valid = 1'b1;
    tick();
    chk1("rst_wren", pm_wren, 1'b0);
    chk8("rst_checksum", checksum, 8'h00);
    tick();
    chk1("rst_load_ignored", busy, 1'b0);
    reset = 1'b0; load_req = 1'b0; byte_valid = 1'b0;
    hold_cycles(n);
    chkn("rst_hold_cycles", n, 4);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      int p, lr, cyc;
      p   = int'($urandom_range(0, 100));
      lr  = int'($urandom_range(0, 12));
      cyc = int'($urandom_range(20, 120));
      for (int c = 0; c < cyc; c++) begin
        byte_valid = ($urandom_range(0, 99) < p);
        byte_data  = 8'($urandom);
        load_req   = ($urandom_range(0, 99) < lr);
        load_len   = ($urandom_range(0, 31) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
        reset      = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    reset = 1'b0; load_req = 1'b0; byte_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
